packet_read_arbiter: RTL and testbench

Sits between the packet buffer's read side and the N PacketPlayer units of one partition. Round-robins among PPs that have a free staging slot and a non-empty FIFO, pops one descriptor per cycle from the shared BRAM, and holds each descriptor in a per-PP one-entry slot. Each PP drains its slot with a valid/ack handshake. This hides the buffer's one-cycle read latency and the single shared read port from the PPs.

---
 rtl/packet_read_arbiter_pkg.sv | 24 ++
 rtl/packet_read_arbiter_rr.sv | 56 +++++
 rtl/packet_read_arbiter.sv | 144 ++++++++++++++
 tb/tb_packet_read_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_read_arbiter_pkg.sv
// Shared types for the packet read arbiter: slot state encoding
// and an index-width helper.
package packet_read_arbiter_pkg;

    // Per-slot staging state, 2 bits per slot.
    typedef enum logic [1:0] {
        SLOT_EMPTY   = 2'b00,
        SLOT_PENDING = 2'b01,
        SLOT_FULL    = 2'b10
    } slot_state_e;

    // Bits needed to index 'value' entries (minimum 1).
    function automatic int clogb2(input int value);
        int w;
        w = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << w) < value) begin
                w = w + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/packet_read_arbiter_rr.sv
// Rotating-priority one-hot arbiter; remembers the last winner and
// searches from the next index upward.
// Ports:
//   clock, reset   - clock, synchronous active-high reset
//   request[SIZE]  - request vector
//   advance        - commit this cycle's winner as last grant
//   grant[SIZE]    - one-hot winner, all-zero when no request
module packet_read_arbiter_rr
    import packet_read_arbiter_pkg::*;
#(
    parameter int SIZE = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [SIZE-1:0] request,
    input  logic            advance,
    output logic [SIZE-1:0] grant
);

    localparam int IW = clogb2(SIZE);

    logic [IW-1:0] last_q;
    logic [IW-1:0] last_d;
    logic [IW-1:0] win;
    logic          found;
    int            idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        win   = last_q;
        idx   = 0;
        for (int k = 1; k <= SIZE; k++) begin
            idx = (int'(last_q) + k) % SIZE;
            if (!found && request[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win        = IW'(idx);
            end
        end
        last_d = last_q;
        if (advance && found) begin
            last_d = win;
        end
    end

    // Reset to SIZE-1 so index 0 wins the first search.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= IW'(SIZE - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/packet_read_arbiter.sv
// Shares one packet-buffer read port among N PacketPlayers, staging
// each popped descriptor in a per-PP one-entry slot.
// Ports:
//   clock, reset  - clock, synchronous active-high reset
//   enable        - gates new fetches only
//   rd_select     - one-hot pop request to the buffer
//   rd_packet     - buffer data, valid the cycle after rd_select
//   rd_ready      - per-PP FIFO non-empty
//   pp_valid      - slot i holds a descriptor
//   pp_packet     - slot i data at [(i+1)*WIDTH-1 : i*WIDTH]
//   pp_ack        - PP i consumes slot i
module packet_read_arbiter
    import packet_read_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    output logic [N-1:0]       rd_select,
    input  logic [WIDTH-1:0]   rd_packet,
    input  logic [N-1:0]       rd_ready,
    output logic [N-1:0]       pp_valid,
    output logic [N*WIDTH-1:0] pp_packet,
    input  logic [N-1:0]       pp_ack
);

    localparam int IW = clogb2(N);

    slot_state_e      slot_q [N];
    slot_state_e      slot_d [N];
    logic [WIDTH-1:0] data_q [N];

    logic          issue_v_q;
    logic          issue_v_d;
    logic [IW-1:0] issue_id_q;
    logic [IW-1:0] issue_id_d;

    logic [N-1:0] eligible;
    logic [N-1:0] grant;
    logic [N-1:0] capture;

    // Only EMPTY slots compete, so a PENDING slot's stale
    // rd_ready can never cause a second pop of its FIFO.
    // No pops are requested while reset is held.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N; i++) begin
            eligible[i] = enable & ~reset & rd_ready[i] &
                          (slot_q[i] == SLOT_EMPTY);
        end
    end

    packet_read_arbiter_rr #(
        .SIZE(N)
    ) u_rr (
        .clock  (clock),
        .reset  (reset),
        .request(eligible),
        .advance(1'b1),
        .grant  (grant)
    );

    assign rd_select = grant;

    always_comb begin
        issue_v_d  = |grant;
        issue_id_d = issue_id_q;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                issue_id_d = IW'(i);
            end
        end
    end

    // Capture does not look at enable: the pop already happened.
    always_comb begin
        capture = '0;
        for (int i = 0; i < N; i++) begin
            capture[i] = issue_v_q &&
                         (issue_id_q == IW'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            slot_d[i] = slot_q[i];
            unique case (slot_q[i])
                SLOT_EMPTY: begin
                    if (grant[i]) begin
                        slot_d[i] = SLOT_PENDING;
                    end
                end
                SLOT_PENDING: begin
                    if (capture[i]) begin
                        slot_d[i] = SLOT_FULL;
                    end
                end
                SLOT_FULL: begin
                    if (pp_ack[i]) begin
                        slot_d[i] = SLOT_EMPTY;
                    end
                end
                default: begin
                    slot_d[i] = SLOT_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            issue_v_q  <= 1'b0;
            issue_id_q <= '0;
            for (int i = 0; i < N; i++) begin
                slot_q[i] <= SLOT_EMPTY;
            end
        end else begin
            issue_v_q  <= issue_v_d;
            issue_id_q <= issue_id_d;
            for (int i = 0; i < N; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    // Slot data is held until the next capture, never cleared.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (capture[i]) begin
                data_q[i] <= rd_packet;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            pp_valid[i] = (slot_q[i] == SLOT_FULL);
            pp_packet[i*WIDTH +: WIDTH] = data_q[i];
        end
    end

endmodule

// File: tb/tb_packet_read_arbiter.sv
// Directed bench for packet_read_arbiter: vector table plus
// hand-written multi-cycle sequences.
module tb_packet_read_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clock;
    logic           reset;
    logic           enable;
    logic [N-1:0]   rd_select;
    logic [W-1:0]   rd_packet;
    logic [N-1:0]   rd_ready;
    logic [N-1:0]   pp_valid;
    logic [N*W-1:0] pp_packet;
    logic [N-1:0]   pp_ack;

    int tests;
    int fails;

    packet_read_arbiter #(
        .N    (N),
        .WIDTH(W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .rd_select(rd_select),
        .rd_packet(rd_packet),
        .rd_ready (rd_ready),
        .pp_valid (pp_valid),
        .pp_packet(pp_packet),
        .pp_ack   (pp_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [N-1:0] ready;
        logic         en;
        logic [N-1:0] ack;
        logic [W-1:0] pkt;
        logic [N-1:0] exp_sel;
        logic [N-1:0] exp_valid;
        logic         chk;
        int           idx;
        logic [W-1:0] exp_data;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(
        input logic [N-1:0] ready,
        input logic         en,
        input logic [N-1:0] ack,
        input logic [W-1:0] pkt,
        input logic [N-1:0] sel,
        input logic [N-1:0] val,
        input logic         chk,
        input int           idx,
        input logic [W-1:0] dat
    );
        vec_t v;
        v.ready = ready; v.en = en; v.ack = ack;
        v.pkt = pkt; v.exp_sel = sel; v.exp_valid = val;
        v.chk = chk; v.idx = idx; v.exp_data = dat;
        return v;
    endfunction

    task automatic drive(
        input logic [N-1:0] ready,
        input logic         en,
        input logic [N-1:0] ack,
        input logic [W-1:0] pkt
    );
        rd_ready  = ready;
        enable    = en;
        pp_ack    = ack;
        rd_packet = pkt;
        #1;
    endtask

    task automatic chk(
        input string        nm,
        input logic [N-1:0] sel,
        input logic [N-1:0] val
    );
        tests++;
        if (rd_select !== sel || pp_valid !== val) begin
            fails++;
            $display("FAIL %s: rd_select=%b pp_valid=%b, want %b %b",
                     nm, rd_select, pp_valid, sel, val);
        end
    endtask

    task automatic chkd(
        input string        nm,
        input int           idx,
        input logic [W-1:0] dat
    );
        logic [W-1:0] got;
        got = pp_packet[idx*W +: W];
        tests++;
        if (got !== dat) begin
            fails++;
            $display("FAIL %s: slot%0d data=%h, want %h",
                     nm, idx, got, dat);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        drive('1, 1'b1, '0, '0);
        tick();
        tick();
        // Reset held: no pops, nothing valid.
        chk("reset_state", 4'b0000, 4'b0000);
        reset = 1'b0;

        // Single fetch to PP0, then full round-robin with
        // immediate acks, then drain.
        vecs.push_back(mk(4'b0001, 1, 4'b0000, 32'h0,
                          4'b0001, 4'b0000, 0, 0, 32'h0));
        vecs.push_back(mk(4'b0000, 1, 4'b0000, 32'hA5A5_0001,
                          4'b0000, 4'b0000, 0, 0, 32'h0));
        vecs.push_back(mk(4'b0000, 1, 4'b0000, 32'h0,
                          4'b0000, 4'b0001, 1, 0, 32'hA5A5_0001));
        vecs.push_back(mk(4'b0000, 1, 4'b0001, 32'h0,
                          4'b0000, 4'b0001, 1, 0, 32'hA5A5_0001));
        vecs.push_back(mk(4'b0000, 1, 4'b0000, 32'h0,
                          4'b0000, 4'b0000, 1, 0, 32'hA5A5_0001));
        vecs.push_back(mk(4'b1111, 1, 4'b1111, 32'h0,
                          4'b0010, 4'b0000, 0, 0, 32'h0));
        vecs.push_back(mk(4'b1111, 1, 4'b1111, 32'h11,
                          4'b0100, 4'b0000, 0, 0, 32'h0));
        vecs.push_back(mk(4'b1111, 1, 4'b1111, 32'h22,
                          4'b1000, 4'b0010, 1, 1, 32'h11));
        vecs.push_back(mk(4'b1111, 1, 4'b1111, 32'h33,
                          4'b0001, 4'b0100, 1, 2, 32'h22));
        vecs.push_back(mk(4'b1111, 1, 4'b1111, 32'h44,
                          4'b0010, 4'b1000, 1, 3, 32'h33));
        vecs.push_back(mk(4'b1111, 1, 4'b1111, 32'h55,
                          4'b0100, 4'b0001, 1, 0, 32'h44));
        vecs.push_back(mk(4'b1111, 1, 4'b1111, 32'h66,
                          4'b1000, 4'b0010, 1, 1, 32'h55));
        vecs.push_back(mk(4'b0000, 1, 4'b1111, 32'h77,
                          4'b0000, 4'b0100, 1, 2, 32'h66));
        vecs.push_back(mk(4'b0000, 1, 4'b1111, 32'h0,
                          4'b0000, 4'b1000, 1, 3, 32'h77));
        vecs.push_back(mk(4'b0000, 1, 4'b1111, 32'h0,
                          4'b0000, 4'b0000, 0, 0, 32'h0));

        foreach (vecs[k]) begin
            drive(vecs[k].ready, vecs[k].en,
                  vecs[k].ack, vecs[k].pkt);
            chk($sformatf("vec%0d", k),
                vecs[k].exp_sel, vecs[k].exp_valid);
            if (vecs[k].chk) begin
                chkd($sformatf("vec%0d_data", k),
                     vecs[k].idx, vecs[k].exp_data);
            end
            tick();
        end

        // PP2 never acks: one grant only, then held valid.
        drive(4'b0100, 1, 4'b0000, 32'h0);
        chk("pp2_grant", 4'b0100, 4'b0000);
        tick();
        drive(4'b0100, 1, 4'b0000, 32'hC2C2_0001);
        chk("pp2_pending", 4'b0000, 4'b0000);
        tick();
        for (int c = 0; c < 5; c++) begin
            drive(4'b0100, 1, 4'b0000, 32'h0);
            chk($sformatf("pp2_hold%0d", c), 4'b0000, 4'b0100);
            tick();
        end
        chkd("pp2_data", 2, 32'hC2C2_0001);
        drive(4'b0100, 1, 4'b0100, 32'h0);
        chk("pp2_ack", 4'b0000, 4'b0100);
        tick();
        drive(4'b0100, 1, 4'b0000, 32'h0);
        chk("pp2_regrant", 4'b0100, 4'b0000);
        tick();
        drive(4'b0000, 1, 4'b0000, 32'hC2C2_0002);
        tick();
        drive(4'b0000, 1, 4'b0100, 32'h0);
        chk("pp2_second", 4'b0000, 4'b0100);
        chkd("pp2_data2", 2, 32'hC2C2_0002);
        tick();

        // Grant PP1, drop enable the next cycle.
        drive(4'b0010, 1, 4'b0000, 32'h0);
        chk("en_grant", 4'b0010, 4'b0000);
        tick();
        drive(4'b1111, 0, 4'b0000, 32'hBEEF_0001);
        chk("en_low_pend", 4'b0000, 4'b0000);
        tick();
        drive(4'b1111, 0, 4'b0000, 32'h0);
        chk("en_low_full", 4'b0000, 4'b0010);
        chkd("en_low_data", 1, 32'hBEEF_0001);
        tick();
        drive(4'b1111, 0, 4'b0010, 32'h0);
        chk("en_low_ack", 4'b0000, 4'b0010);
        tick();
        drive(4'b1111, 0, 4'b0000, 32'h0);
        chk("en_low_idle", 4'b0000, 4'b0000);
        tick();

        // Reset the cycle after a grant to PP2.
        drive(4'b0100, 1, 4'b0000, 32'h0);
        chk("rst_grant", 4'b0100, 4'b0000);
        tick();
        reset = 1'b1;
        drive(4'b1111, 1, 4'b0000, 32'hDEAD_0001);
        chk("rst_hold", 4'b0000, 4'b0000);
        tick();
        drive(4'b0000, 1, 4'b0000, 32'h0);
        chk("rst_after", 4'b0000, 4'b0000);
        reset = 1'b0;
        tick();
        drive(4'b1111, 1, 4'b0000, 32'h0);
        chk("rst_first_pp0", 4'b0001, 4'b0000);
        tick();
        drive(4'b0000, 1, 4'b0000, 32'h5A5A_0001);
        chk("rst_no_stale", 4'b0000, 4'b0000);
        tick();
        drive(4'b0000, 1, 4'b0001, 32'h0);
        chk("rst_pp0_full", 4'b0000, 4'b0001);
        chkd("rst_pp0_data", 0, 32'h5A5A_0001);
        tick();

        // Ack on EMPTY slots, then on a PENDING slot.
        drive(4'b0000, 1, 4'b1111, 32'h0);
        chk("ack_empty", 4'b0000, 4'b0000);
        tick();
        drive(4'b0010, 1, 4'b0000, 32'h0);
        chk("ackp_grant", 4'b0010, 4'b0000);
        tick();
        drive(4'b0000, 1, 4'b0010, 32'hC0DE_0001);
        chk("ackp_pend", 4'b0000, 4'b0000);
        tick();
        drive(4'b0000, 1, 4'b0000, 32'h0);
        chk("ackp_full", 4'b0000, 4'b0010);
        chkd("ackp_data", 1, 32'hC0DE_0001);
        tick();
        drive(4'b0000, 1, 4'b0010, 32'h0);
        tick();
        drive(4'b0000, 1, 4'b0000, 32'h0);
        chk("ackp_done", 4'b0000, 4'b0000);
        chkd("ackp_hold", 1, 32'hC0DE_0001);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
